alu_multicycle: RTL

//   Parametrised, handshaked successor of the combinational R-type ALU.
//   - Decodes a 32-bit MIPS R-type instruction and executes it on operands gr1 (rs value) and gr2 (rt value).
//   - Logic and arithmetic ops complete in one cycle.
//   - Shifts run iteratively, SHIFT_STEP bits per cycle.
//   - Result is held with flags until the consumer accepts it. Sits between register read and writeback.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_shift_step.sv | 28 ++
 rtl/alu_multicycle.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared decode constants and enums for the multicycle R-type ALU.
//   - opcode/func encodings of the supported MIPS R-type instructions
//   - op-class, FSM state and shift-kind enums
//   - decode helpers used at instruction accept
package alu_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {CLS_LOGIC, CLS_ARITH, CLS_SHIFT, CLS_ILLEGAL} op_class_e;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_kind_e;

    function automatic op_class_e decode_class(input logic [5:0] opcode, input logic [5:0] func);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        if (opcode == OPC_RTYPE) begin
            case (func)
                FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:    cls = CLS_SHIFT;
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLT, FN_SLTU:    cls = CLS_ARITH;
                FN_AND, FN_OR, FN_XOR, FN_NOR:                        cls = CLS_LOGIC;
                default:                                              cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

    // Shift funcs share their low two bits between fixed and variable forms.
    function automatic shift_kind_e decode_kind(input logic [1:0] func_lo);
        shift_kind_e kind;
        case (func_lo)
            2'b00:   kind = SH_SLL;
            2'b10:   kind = SH_SRL;
            default: kind = SH_SRA;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational single step of the iterative shifter.
//   data   in   WIDTH   value being shifted
//   amt    in   AMT_W   positions to shift this step (0..SHIFT_STEP)
//   kind   in   enum    SLL / SRL / SRA
//   result out  WIDTH   shifted value
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4,
    parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  shift_kind_e      kind,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        case (kind)
            SH_SLL:  result = data << amt;
            SH_SRL:  result = data >> amt;
            default: result = $signed(data) >>> amt;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked R-type ALU; logic/arith ops take one EXEC cycle,
// shifts iterate SHIFT_STEP positions per EXEC cycle plus one result cycle.
//   clk, reset            clock, async active-high reset
//   in_valid/in_ready     instruction handshake (ready only in IDLE)
//   i_datain, gr1, gr2    instruction word, rs and rt operand values
//   out_valid/out_ready   result handshake (valid only in DONE)
//   c, rd_addr            result and destination register
//   zero, neg, overflow, illegal   result flags
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      i_datain,
    input  logic [WIDTH-1:0] gr1,
    input  logic [WIDTH-1:0] gr2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [4:0]       rd_addr,
    output logic             zero,
    output logic             neg,
    output logic             overflow,
    output logic             illegal
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;                    // remaining count must hold WIDTH itself
    localparam int SW = $clog2(SHIFT_STEP + 1);

    state_e           state, state_n;
    op_class_e        cls_q, in_cls;
    shift_kind_e      kind_q;
    logic [5:0]       func_q;
    logic [WIDTH-1:0] a_q, b_q, step_out, res;
    logic [CW-1:0]    rem_q, in_amt;
    logic [SW-1:0]    step_amt;
    logic             accept, ov, ill;
    logic             unused_bits;

    assign unused_bits = ^{i_datain[25:16], gr1[WIDTH-1:LW]};

    assign accept = in_valid && (state == ST_IDLE);
    assign in_cls = decode_class(i_datain[31:26], i_datain[5:0]);

    // Shift distance: variable forms use the low log2(WIDTH) bits of rs;
    // fixed forms saturate shamt at WIDTH so narrow datapaths fill completely.
    always_comb begin
        in_amt = '0;
        if (i_datain[2])
            in_amt = CW'(gr1[LW-1:0]);
        else if (32'(i_datain[10:6]) >= 32'(WIDTH))
            in_amt = CW'(WIDTH);
        else
            in_amt = CW'(i_datain[10:6]);
    end

    assign step_amt = (rem_q >= CW'(SHIFT_STEP)) ? SW'(SHIFT_STEP) : SW'(rem_q);

    alu_shift_step #(.WIDTH(WIDTH), .SHIFT_STEP(SHIFT_STEP), .AMT_W(SW)) u_step (
        .data   (b_q),
        .amt    (step_amt),
        .kind   (kind_q),
        .result (step_out)
    );

    // Result of the final EXEC cycle; shifts have already accumulated in b_q.
    always_comb begin
        res = '0;
        ov  = 1'b0;
        ill = 1'b0;
        case (cls_q)
            CLS_SHIFT:   res = b_q;
            CLS_ILLEGAL: ill = 1'b1;
            default: begin
                case (func_q)
                    FN_ADD: begin
                        res = a_q + b_q;
                        ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    FN_ADDU: res = a_q + b_q;
                    FN_SUB: begin
                        res = a_q - b_q;
                        ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    FN_SUBU: res = a_q - b_q;
                    FN_AND:  res = a_q & b_q;
                    FN_OR:   res = a_q | b_q;
                    FN_XOR:  res = a_q ^ b_q;
                    FN_NOR:  res = ~(a_q | b_q);
                    FN_SLT:  res = WIDTH'($signed(a_q) < $signed(b_q));
                    FN_SLTU: res = WIDTH'(a_q < b_q);
                    default: res = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_n = ST_EXEC;
            end
            ST_EXEC: begin
                if (rem_q == '0) state_n = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q    <= CLS_ILLEGAL;
            kind_q   <= SH_SLL;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            c        <= '0;
            rd_addr  <= '0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept) begin
            cls_q   <= in_cls;
            kind_q  <= decode_kind(i_datain[1:0]);
            func_q  <= i_datain[5:0];
            a_q     <= gr1;
            b_q     <= gr2;
            rem_q   <= (in_cls == CLS_SHIFT) ? in_amt : '0;
            rd_addr <= i_datain[15:11];
        end else if (state == ST_EXEC) begin
            if (rem_q != '0) begin
                b_q   <= step_out;
                rem_q <= rem_q - CW'(step_amt);
            end else begin
                c        <= res;
                zero     <= (res == '0);
                neg      <= res[WIDTH-1];
                overflow <= ov;
                illegal  <= ill;
            end
        end
    end

endmodule
